in_debounce: RTL

Input-conditioning stage that sits directly upstream of the inverter on `ui_in[0]`. It synchronises the raw pad level, rejects glitches shorter than a programmable hold time, and drives a clean level to the inverter's `a` input. It also produces one-cycle edge pulses and a wrapping rising-edge event count for the spare `uo_out` bits.

---
 rtl/in_debounce_if.sv | 23 ++
 rtl/in_debounce.sv | 128 ++++++++++++
 2 files changed

// File: rtl/in_debounce_if.sv
// rtl/in_debounce_if.sv - control and status bundle for the in_debounce input conditioner
interface in_debounce_if #(
  parameter int EVT_W = 8
);
  logic             ena;
  logic             din;
  logic             clr;
  logic             clean;
  logic             rise;
  logic             fall;
  logic             stable;
  logic [EVT_W-1:0] evt_count;

  modport master (
    output ena, din, clr,
    input  clean, rise, fall, stable, evt_count
  );

  modport slave (
    input  ena, din, clr,
    output clean, rise, fall, stable, evt_count
  );
endinterface

// File: rtl/in_debounce.sv
// rtl/in_debounce.sv - pad synchroniser, hold-time debouncer, edge pulses and rise event counter
module in_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int EVT_W           = 8
) (
  input logic         clk,
  input logic         rst_n,
  in_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2;
  logic             clean_q, rise_q, fall_q, stable_q;
  logic [EVT_W-1:0] evt_q;

  // The synchroniser is never gated so the held FSM resumes on a fresh level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.din;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE_LO;
      cnt      <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stable_q <= 1'b1;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (bus.ena) begin
        case (state)
          IDLE_LO: begin
            if (s2) begin
              state    <= WAIT_HI;
              cnt      <= CNT_ONE;
              stable_q <= 1'b0;
            end else begin
              cnt <= '0;
            end
          end
          WAIT_HI: begin
            if (!s2) begin
              state    <= IDLE_LO;
              cnt      <= '0;
              stable_q <= 1'b1;
            end else if (cnt == CNT_LAST) begin
              state    <= IDLE_HI;
              cnt      <= '0;
              clean_q  <= 1'b1;
              rise_q   <= 1'b1;
              stable_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE_HI: begin
            if (!s2) begin
              state    <= WAIT_LO;
              cnt      <= CNT_ONE;
              stable_q <= 1'b0;
            end else begin
              cnt <= '0;
            end
          end
          WAIT_LO: begin
            if (s2) begin
              state    <= IDLE_HI;
              cnt      <= '0;
              stable_q <= 1'b1;
            end else if (cnt == CNT_LAST) begin
              state    <= IDLE_LO;
              cnt      <= '0;
              clean_q  <= 1'b0;
              fall_q   <= 1'b1;
              stable_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state    <= IDLE_LO;
            cnt      <= '0;
            clean_q  <= 1'b0;
            stable_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Counts the registered rise pulse, so it trails rise by one edge; clear dominates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (bus.clr) begin
      evt_q <= '0;
    end else if (bus.ena && rise_q) begin
      evt_q <= evt_q + EVT_W'(1);
    end
  end

  assign bus.clean     = clean_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.stable    = stable_q;
  assign bus.evt_count = evt_q;

endmodule
